// File: rtl/openram_bist_ctrl.sv
// openram_bist_ctrl: March C- built-in self-test sequencer driving an OpenRAM 1rw SRAM port.
// Define OPENRAM_BIST_FAIL_LOG_EN to keep the first-fail address and the saturating mismatch count.
module openram_bist_ctrl #(
    parameter  int ADDR_W  = 8,
    parameter  int DATA_W  = 32,
    localparam int WMASK_W = DATA_W / 8
) (
    input  logic               wb_clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               fail,
    output logic [ADDR_W-1:0]  fail_addr,
    output logic [15:0]        fail_count,
    output logic               csb0,
    output logic               web0,
    output logic [WMASK_W-1:0] wmask0,
    output logic [ADDR_W-1:0]  addr0,
    output logic [DATA_W-1:0]  din0,
    input  logic [DATA_W-1:0]  dout0
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0, M0 = 3'd1, M1 = 3'd2, M2 = 3'd3,
        M3    = 3'd4, M4 = 3'd5, M5 = 3'd6, DRAIN = 3'd7
    } state_e;

    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    function automatic logic elem_up(input state_e s);
        case (s)
            M3, M4:  elem_up = 1'b0;
            default: elem_up = 1'b1;
        endcase
    endfunction

    function automatic logic elem_single(input state_e s);
        case (s)
            M0, M5:  elem_single = 1'b1;
            default: elem_single = 1'b0;
        endcase
    endfunction

    function automatic state_e next_elem(input state_e s);
        case (s)
            M0:      next_elem = M1;
            M1:      next_elem = M2;
            M2:      next_elem = M3;
            M3:      next_elem = M4;
            M4:      next_elem = M5;
            default: next_elem = DRAIN;
        endcase
    endfunction

    // Phase 0 of a two-operation element is its read, phase 1 its write.
    function automatic logic op_is_read(input state_e s, input logic ph);
        case (s)
            M0:      op_is_read = 1'b0;
            M5:      op_is_read = 1'b1;
            default: op_is_read = ~ph;
        endcase
    endfunction

    function automatic logic op_bit(input state_e s, input logic ph);
        case (s)
            M1, M3:  op_bit = ph;
            M2, M4:  op_bit = ~ph;
            default: op_bit = 1'b0;
        endcase
    endfunction

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                phase_q, phase_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                csb0_q, csb0_d;
    logic                web0_q, web0_d;
    logic [WMASK_W-1:0]  wmask0_q, wmask0_d;
    logic [ADDR_W-1:0]   addr0_q, addr0_d;
    logic [DATA_W-1:0]   din0_q, din0_d;
    logic                exp_q, exp_d;
    logic                pend_q, pend_d;
    logic                cmp_exp_q, cmp_exp_d;
    logic                fail_q, fail_d;
    logic                last_addr_s;
    logic                abort_s;
    logic                start_acc_s;
    logic                mismatch_s;

    assign abort_s     = abort && (state_q != IDLE);
    assign start_acc_s = (state_q == IDLE) && start && !abort;
    assign mismatch_s  = pend_q && (dout0 != {DATA_W{cmp_exp_q}}) && !abort_s;

    // Sequence through the March elements one SRAM operation per cycle
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        phase_d     = phase_q;
        last_addr_s = elem_up(state_q) ? (addr_q == ADDR_MAX) : (addr_q == '0);
        case (state_q)
            IDLE: begin
                if (start_acc_s) begin
                    state_d = M0;
                    addr_d  = '0;
                    phase_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            DRAIN: state_d = IDLE;
            default: begin
                if (!elem_single(state_q) && !phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (last_addr_s) begin
                        state_d = next_elem(state_q);
                        addr_d  = elem_up(next_elem(state_q)) ? '0 : ADDR_MAX;
                    end else if (elem_up(state_q)) begin
                        addr_d = addr_q + ADDR_ONE;
                    end else begin
                        addr_d = addr_q - ADDR_ONE;
                    end
                end
            end
        endcase
        if (abort_s) begin
            state_d = IDLE;
            addr_d  = '0;
            phase_d = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // SRAM drive and status for the coming cycle, decoded from the next state so the pins come straight from flops
    always_comb begin
        csb0_d    = 1'b1;
        web0_d    = 1'b1;
        wmask0_d  = '0;
        addr0_d   = '0;
        din0_d    = '0;
        exp_d     = 1'b0;
        busy_d    = (state_d != IDLE);
        done_d    = (state_q == DRAIN) && !abort;
        pend_d    = !csb0_q && web0_q && !abort_s;
        cmp_exp_d = exp_q;
        fail_d    = start_acc_s ? 1'b0 : (fail_q | mismatch_s);
        if (state_d != IDLE && state_d != DRAIN) begin
            csb0_d  = 1'b0;
            addr0_d = addr_d;
            if (op_is_read(state_d, phase_d)) begin
                exp_d = op_bit(state_d, phase_d);
            end else begin
                web0_d   = 1'b0;
                wmask0_d = {WMASK_W{1'b1}};
                din0_d   = {DATA_W{op_bit(state_d, phase_d)}};
            end
        end else begin
            csb0_d = 1'b1;
        end
    end

    // Controller state, SRAM pins and the one-cycle-delayed read compare pipeline
    always_ff @(posedge wb_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            phase_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            csb0_q    <= 1'b1;
            web0_q    <= 1'b1;
            wmask0_q  <= '0;
            addr0_q   <= '0;
            din0_q    <= '0;
            exp_q     <= 1'b0;
            pend_q    <= 1'b0;
            cmp_exp_q <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            phase_q   <= phase_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            csb0_q    <= csb0_d;
            web0_q    <= web0_d;
            wmask0_q  <= wmask0_d;
            addr0_q   <= addr0_d;
            din0_q    <= din0_d;
            exp_q     <= exp_d;
            pend_q    <= pend_d;
            cmp_exp_q <= cmp_exp_d;
            fail_q    <= fail_d;
        end
    end

`ifdef OPENRAM_BIST_FAIL_LOG_EN
    logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [15:0]       fail_count_q, fail_count_d;

    // First-fail address capture and saturating mismatch count
    always_comb begin
        cmp_addr_d   = addr0_q;
        fail_addr_d  = fail_addr_q;
        fail_count_d = fail_count_q;
        if (start_acc_s) begin
            fail_addr_d  = '0;
            fail_count_d = 16'd0;
        end else if (mismatch_s) begin
            fail_addr_d  = fail_q ? fail_addr_q : cmp_addr_q;
            fail_count_d = (fail_count_q == 16'hFFFF) ? 16'hFFFF : (fail_count_q + 16'd1);
        end else begin
            fail_count_d = fail_count_q;
        end
    end

    // Fail log registers
    always_ff @(posedge wb_clock or negedge reset_n) begin
        if (!reset_n) begin
            cmp_addr_q   <= '0;
            fail_addr_q  <= '0;
            fail_count_q <= 16'd0;
        end else begin
            cmp_addr_q   <= cmp_addr_d;
            fail_addr_q  <= fail_addr_d;
            fail_count_q <= fail_count_d;
        end
    end

    assign fail_addr  = fail_addr_q;
    assign fail_count = fail_count_q;
`else
    assign fail_addr  = '0;
    assign fail_count = 16'd0;
`endif

    assign busy   = busy_q;
    assign done   = done_q;
    assign fail   = fail_q;
    assign csb0   = csb0_q;
    assign web0   = web0_q;
    assign wmask0 = wmask0_q;
    assign addr0  = addr0_q;
    assign din0   = din0_q;

endmodule

// File: doc/openram_bist_ctrl.md
OPENRAM_BIST_CTRL -- requirements
Module: openram_bist_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, giving the SRAM address width and a depth of 2^ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 32, giving the SRAM word width; WMASK_W = DATA_W/8.
REQ-003 SHALL have port wb_clock, input, 1 bit: the single clock; one clock, all state on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: single-cycle request to run a March C- test.
REQ-006 SHALL have port abort, input, 1 bit: terminates a running test.
REQ-007 SHALL have port busy, output, 1 bit: high while a test runs.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse at normal completion.
REQ-009 SHALL have port fail, output, 1 bit: sticky mismatch flag.
REQ-010 SHALL have port fail_addr, output, ADDR_W bits: address of the first mismatch.
REQ-011 SHALL have port fail_count, output, 16 bits: saturating mismatch count.
REQ-012 SHALL have ports csb0, web0 (1 bit each), wmask0 (WMASK_W bits), addr0 (ADDR_W bits) and din0 (DATA_W bits), all outputs: the SRAM 1rw port drive.
REQ-013 SHALL have port dout0, input, DATA_W bits: SRAM 1rw read data.

Function
REQ-014 SHALL run March C- as six elements: M0 up(w0); M1 up(r0,w1); M2 up(r1,w0); M3 down(r0,w1); M4 down(r1,w0); M5 up(r0). "0" is all-zeros and "1" is all-ones.
REQ-015 SHALL use states IDLE, M0..M5, DRAIN, and return to IDLE after DRAIN.
REQ-016 SHALL issue one SRAM operation per cycle with csb0=0; a read drives web0=1 and wmask0=0; a write drives web0=0 and wmask0 all-ones.
REQ-017 SHALL hold csb0=1, web0=1 and wmask0=0 outside M0..M5; addr0 and din0 are then don't-care but SHALL be driven to 0.
REQ-018 SHALL make up-elements count addr from 0 to 2^ADDR_W-1 and down-elements count from 2^ADDR_W-1 to 0, with the element advancing on address wrap.
REQ-019 SHALL register the expected value of each read and compare it with dout0 exactly one cycle after the read cycle.
REQ-020 SHALL make DRAIN last one cycle, to compare the final M5 read.
REQ-021 SHALL give the test 10*2^ADDR_W consecutive operation cycles.
REQ-022 SHALL assert busy from the cycle after start is sampled in IDLE through DRAIN inclusive.
REQ-023 SHALL pulse done for one cycle, in the cycle after DRAIN, with busy low.
REQ-024 SHALL ignore start while busy.
REQ-025 SHALL clear fail, fail_addr and fail_count when start is accepted.
REQ-026 SHALL latch fail=1 on any mismatch and hold it until the next accepted start or reset.
REQ-027 SHALL make fail_count increment by 1 per mismatching read and saturate at 16'hFFFF.
REQ-028 SHALL, when abort=1 while busy, go to IDLE on the next edge: csb0=1 that cycle, no done, and any read compare still pending is discarded.
REQ-029 SHALL give abort priority over start when both are asserted in IDLE, so that no test starts.
REQ-030 SHALL make abort in IDLE a no-op.

Reset
REQ-031 SHALL, on reset_n=0, immediately force: state IDLE, busy=0, done=0, fail=0, fail_addr=0, fail_count=0, csb0=1, web0=1, wmask0=0, addr0=0, din0=0.
REQ-032 SHALL abandon a test in progress when reset is asserted mid-test and leave it not resumed; release of reset SHALL NOT start a test.

Configuration
REQ-033 SHALL, with macro OPENRAM_BIST_FAIL_LOG_EN defined, make fail_addr capture the address of the first mismatch only after each start, and make fail_count operate per REQ-027.
REQ-034 SHALL, without OPENRAM_BIST_FAIL_LOG_EN, tie fail_addr and fail_count constantly to 0, remove their logic, and leave fail unchanged.

Verification
REQ-035 SHALL cover, with ADDR_W=2 and a fault-free model: start pulse -> busy for 41 cycles (40 operations plus DRAIN), done one cycle, fail=0, address order 0..3 for up-elements and 3..0 for down-elements.
REQ-036 SHALL cover, with ADDR_W=2, a model with bit 0 of address 2 stuck-at-1: -> fail=1, fail_addr=2, fail_count=3 (the M1 r0, M3 r0 and M5 r0 reads mismatch).
REQ-037 SHALL cover abort asserted at operation cycle 10 -> csb0=1 next cycle, busy=0, no done pulse; a new start runs the full 40 operations.
REQ-038 SHALL cover reset_n pulsed low mid-M2 -> all outputs at REQ-031 values asynchronously, no activity after release until start.
REQ-039 SHALL cover start re-pulsed while busy -> no effect, with done exactly 41 cycles after the original start.
REQ-040 SHALL cover a build without OPENRAM_BIST_FAIL_LOG_EN with the stuck-at model -> fail=1, fail_addr=0, fail_count=0.
